vcmd_spi_tx: RTL

SPI-mode-0 command transmitter: serializes one video-memory write burst (19-bit start address plus N data bytes) onto Sclk/Mosi/CSel. This is the host-side initiator for the VGA board's SPI receiver and command decoder. It is used in the host/stimulus FPGA and as the bus-functional driver in the top-level VGA bench. It is clocked by a single fast clock and generates Sclk by division.

---
 rtl/vga_pkg.sv | 31 +++
 rtl/spi_shift_tx.sv | 70 +++++++
 rtl/vcmd_spi_tx.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the video-memory command link.
// Holds the write-burst header magic, the header length in bytes, the
// transmitter frame-state enum and a helper that builds header byte N from a
// 19-bit start address.
package vga_pkg;

    localparam logic [4:0]  VCMD_HDR_MAGIC = 5'b10000;
    localparam int unsigned VCMD_HDR_BYTES = 3;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        STALL,
        HOLD,
        GAP
    } vcmd_state_e;

    // Header byte idx of a write burst: {magic, A[18:16]}, A[15:8], A[7:0].
    function automatic logic [7:0] vcmd_hdr_byte(input logic [18:0] addr,
                                                 input logic [1:0]  idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = {VCMD_HDR_MAGIC, addr[18:16]};
            2'd1:    b = addr[15:8];
            default: b = addr[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_shift_tx.sv
// SPI mode-0 bit engine: Sclk divider plus 8-bit MSB-first shifter.
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_load, i_byte     load a new byte; restarts the divider with Sclk low
//   i_count            run the divider (also used to time non-shifting phases)
//   i_shift            let the divider drive Sclk phases and shift bits
//   o_sclk, o_mosi     registered SPI clock and data
//   o_div_end          divider is on the last cycle of a half period
//   o_byte_done        last cycle of the high phase of bit 7
module spi_shift_tx #(
    parameter int unsigned CLKDIV = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    input  logic       i_count,
    input  logic       i_shift,
    output logic       o_sclk,
    output logic       o_mosi,
    output logic       o_div_end,
    output logic       o_byte_done
);

    localparam int unsigned     DIVW    = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [DIVW-1:0] DIV_MAX = DIVW'(CLKDIV - 1);

    logic [DIVW-1:0] r_div;
    logic [2:0]      r_bit;
    logic [7:0]      r_shreg;
    logic            r_sclk;
    logic            w_div_end;

    assign w_div_end   = (r_div == DIV_MAX);
    assign o_div_end   = w_div_end;
    assign o_byte_done = i_shift && r_sclk && w_div_end && (r_bit == 3'd7);
    assign o_sclk      = r_sclk;
    assign o_mosi      = r_shreg[7];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div   <= '0;
            r_bit   <= '0;
            r_shreg <= '0;
            r_sclk  <= 1'b0;
        end else if (i_load) begin
            r_div   <= '0;
            r_bit   <= '0;
            r_shreg <= i_byte;
            r_sclk  <= 1'b0;
        end else if (i_count) begin
            r_div <= w_div_end ? '0 : r_div + DIVW'(1);
            if (i_shift && w_div_end) begin
                if (!r_sclk) begin
                    r_sclk <= 1'b1;
                end else begin
                    r_sclk <= 1'b0;
                    // After bit 7 Mosi keeps its value until the next load.
                    if (r_bit != 3'd7) begin
                        r_shreg <= {r_shreg[6:0], 1'b0};
                        r_bit   <= r_bit + 3'd1;
                    end
                end
            end
        end else begin
            r_div <= '0;
        end
    end

endmodule

// File: rtl/vcmd_spi_tx.sv
// Video-memory write-burst SPI transmitter (mode 0, MSB first).
// Sends {magic, A[18:16]}, A[15:8], A[7:0] then LenIn data bytes per frame.
// Ports:
//   Clk, Reset           clock, synchronous active-high reset
//   Start, AddrIn, LenIn burst request and its parameters (taken when idle)
//   ByteIn, ByteValid,   data byte stream into a one-byte holding register
//   ByteReady
//   Busy                 frame in progress, Start through end of the CSel gap
//   Sclk, Mosi, CSel     registered SPI outputs
module vcmd_spi_tx
    import vga_pkg::*;
#(
    parameter int unsigned AWIDTH = 19,
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned LWIDTH = 16,
    parameter int unsigned CLKDIV = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [AWIDTH-1:0] AddrIn,
    input  logic [LWIDTH-1:0] LenIn,
    input  logic [DWIDTH-1:0] ByteIn,
    input  logic              ByteValid,
    output logic              ByteReady,
    output logic              Busy,
    output logic              Sclk,
    output logic              Mosi,
    output logic              CSel
);

    vcmd_state_e       r_state, w_state_d;
    logic [AWIDTH-1:0] r_addr, w_addr_d;
    logic [LWIDTH-1:0] r_remain, w_remain_d;   // data bytes not yet in the shifter
    logic [1:0]        r_hdr_cnt, w_hdr_cnt_d; // header bytes already loaded
    logic [DWIDTH-1:0] r_hold, w_hold_d;
    logic              r_hold_full, w_hold_full_d;
    logic              r_csel;

    logic       w_load;
    logic [7:0] w_load_byte;
    logic       w_count;
    logic       w_shift;
    logic       w_take_hold;
    logic       w_div_end;
    logic       w_byte_done;
    logic       w_accept;

    // With the holding register empty, r_remain is also the count still owed.
    assign ByteReady = ((r_state == SHIFT) || (r_state == STALL)) && !r_hold_full &&
                       (r_remain != '0);
    assign Busy      = (r_state != IDLE);
    assign CSel      = r_csel;
    assign w_accept  = ByteValid && ByteReady;

    always_comb begin
        w_state_d     = r_state;
        w_addr_d      = r_addr;
        w_remain_d    = r_remain;
        w_hdr_cnt_d   = r_hdr_cnt;
        w_hold_d      = r_hold;
        w_hold_full_d = r_hold_full;
        w_load        = 1'b0;
        w_load_byte   = '0;
        w_count       = 1'b0;
        w_shift       = 1'b0;
        w_take_hold   = 1'b0;

        if (w_accept) begin
            w_hold_d      = ByteIn;
            w_hold_full_d = 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_state_d   = SETUP;
                    w_addr_d    = AddrIn;
                    w_remain_d  = LenIn;
                    w_hdr_cnt_d = 2'd1;
                    w_load      = 1'b1;
                    w_load_byte = vcmd_hdr_byte(19'(AddrIn), 2'd0);
                end
            end
            SETUP: begin
                w_count = 1'b1;
                if (w_div_end) w_state_d = SHIFT;
            end
            SHIFT: begin
                w_count = 1'b1;
                w_shift = 1'b1;
                if (w_byte_done) begin
                    if (r_hdr_cnt < 2'(VCMD_HDR_BYTES)) begin
                        w_load      = 1'b1;
                        w_load_byte = vcmd_hdr_byte(19'(r_addr), r_hdr_cnt);
                        w_hdr_cnt_d = r_hdr_cnt + 2'd1;
                    end else if (r_hold_full) begin
                        w_take_hold = 1'b1;
                    end else if (r_remain != '0) begin
                        w_state_d = STALL;
                    end else begin
                        w_state_d = HOLD;
                    end
                end
            end
            STALL: begin
                if (r_hold_full) begin
                    w_take_hold = 1'b1;
                    w_state_d   = SHIFT;
                end
            end
            HOLD: begin
                w_count = 1'b1;
                if (w_div_end) w_state_d = GAP;
            end
            GAP: begin
                w_count = 1'b1;
                if (w_div_end) w_state_d = IDLE;
            end
            default: w_state_d = IDLE;
        endcase

        if (w_take_hold) begin
            w_load        = 1'b1;
            w_load_byte   = 8'(r_hold);
            w_hold_full_d = 1'b0;
            if (r_remain != '0) w_remain_d = r_remain - LWIDTH'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_remain    <= '0;
            r_hdr_cnt   <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_csel      <= 1'b1;
        end else begin
            r_state     <= w_state_d;
            r_addr      <= w_addr_d;
            r_remain    <= w_remain_d;
            r_hdr_cnt   <= w_hdr_cnt_d;
            r_hold      <= w_hold_d;
            r_hold_full <= w_hold_full_d;
            r_csel      <= (w_state_d == IDLE) || (w_state_d == GAP);
        end
    end

    spi_shift_tx #(
        .CLKDIV(CLKDIV)
    ) u_shift (
        .i_clk      (Clk),
        .i_reset    (Reset),
        .i_load     (w_load),
        .i_byte     (w_load_byte),
        .i_count    (w_count),
        .i_shift    (w_shift),
        .o_sclk     (Sclk),
        .o_mosi     (Mosi),
        .o_div_end  (w_div_end),
        .o_byte_done(w_byte_done)
    );

endmodule
